// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control FSM for the single-issue RISC datapath. Each
//   instruction walks FETCH/DECODE/EXEC/MEM/WB, one state per clock.
//   Interrupt entry (INTR) is inserted between instructions, and a HALT
//   state can be woken by an interrupt.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   opcode     in   [5:0] opcode field of the instruction register
//   mem_ready  in   data memory finishes the current access this cycle
//   INT        in   level-sensitive interrupt request
//   ir_en      out  load the instruction register
//   upd_pc     out  PC write enable
//   pc_sel     out  [1:0] PC source: 00 NPC, 01 branch, 10 vector, 11 EPC
//   rd_mem     out  data memory read strobe
//   wr_mem     out  data memory write strobe
//   wr_reg     out  register bank write enable
//   int_ack    out  one-cycle pulse; datapath latches PC into EPC
//   in_isr     out  interrupt service in progress
//   halted     out  core halted
//   state      out  [2:0] current FSM state (debug)
//   instret    out  [31:0] retired-instruction count
//
// Build option
//   SEQ_PERF_CNT_EN : when defined, instret is a live 32-bit counter;
//                     otherwise no counter is built and instret reads 0.
module multicycle_sequencer #(
  parameter logic [5:0] OP_ALU  = 6'h00,
  parameter logic [5:0] OP_ALUI = 6'h01,
  parameter logic [5:0] OP_LD   = 6'h02,
  parameter logic [5:0] OP_ST   = 6'h03,
  parameter logic [5:0] OP_BR   = 6'h04,
  parameter logic [5:0] OP_RETI = 6'h05,
  parameter logic [5:0] OP_HALT = 6'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        INT,
  output logic        ir_en,
  output logic        upd_pc,
  output logic [1:0]  pc_sel,
  output logic        rd_mem,
  output logic        wr_mem,
  output logic        wr_reg,
  output logic        int_ack,
  output logic        in_isr,
  output logic        halted,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_INTR   = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] PC_NPC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;
  localparam logic [1:0] PC_EPC = 2'b11;

  logic [2:0] state_q, state_d;
  logic       in_isr_q, in_isr_d;
  logic       retire;      // an instruction completes at this edge
  logic       halt_enter;  // HALT opcode decoded; counted like a retire
  logic       take_int;

  // No nesting: a request is only honoured outside the ISR.
  assign take_int = INT & ~in_isr_q;

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = S_FETCH;
    in_isr_d   = in_isr_q;
    retire     = 1'b0;
    halt_enter = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_ALU || opcode == OP_ALUI || opcode == OP_LD ||
            opcode == OP_ST  || opcode == OP_BR   || opcode == OP_RETI) begin
          state_d = S_EXEC;
        end else if (opcode == OP_HALT) begin
          state_d    = S_HALT;
          halt_enter = 1'b1;
        end else begin
          retire = 1'b1;  // unknown opcode executes as a NOP
        end
      end
      S_EXEC: begin
        if (opcode == OP_ALU || opcode == OP_ALUI) begin
          state_d = S_WB;
        end else if (opcode == OP_LD || opcode == OP_ST) begin
          state_d = S_MEM;
        end else if (opcode == OP_BR) begin
          retire = 1'b1;
        end else if (opcode == OP_RETI) begin
          retire   = 1'b1;
          in_isr_d = 1'b0;
        end
      end
      S_MEM: begin
        if (opcode == OP_LD) begin
          state_d = mem_ready ? S_WB : S_MEM;
        end else if (opcode == OP_ST) begin
          if (mem_ready) retire = 1'b1;
          else           state_d = S_MEM;
        end
      end
      S_WB:   retire = 1'b1;
      S_INTR: in_isr_d = 1'b1;
      S_HALT: state_d = take_int ? S_INTR : S_HALT;
      default: state_d = S_FETCH;  // code 7 recovers to FETCH
    endcase
    // take_int uses the registered in_isr, so a RETI retire still sees the
    // ISR as active and the pending request waits one more instruction.
    if (retire) state_d = take_int ? S_INTR : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
    end
  end

  // ---------------------------------------------------------------------
  // Strobe decode. Gated with rst so a reset assertion removes every
  // strobe immediately, without waiting for the state flops.
  // ---------------------------------------------------------------------
  always_comb begin
    ir_en   = 1'b0;
    upd_pc  = 1'b0;
    pc_sel  = PC_NPC;
    rd_mem  = 1'b0;
    wr_mem  = 1'b0;
    wr_reg  = 1'b0;
    int_ack = 1'b0;
    halted  = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: ir_en = 1'b1;
        S_DECODE: begin
          if (!(opcode == OP_ALU || opcode == OP_ALUI || opcode == OP_LD ||
                opcode == OP_ST  || opcode == OP_BR   || opcode == OP_RETI ||
                opcode == OP_HALT)) begin
            upd_pc = 1'b1;
            pc_sel = PC_NPC;
          end
        end
        S_EXEC: begin
          if (opcode == OP_BR) begin
            upd_pc = 1'b1;
            pc_sel = PC_BR;
          end else if (opcode == OP_RETI) begin
            upd_pc = 1'b1;
            pc_sel = PC_EPC;
          end
        end
        S_MEM: begin
          if (opcode == OP_LD) rd_mem = 1'b1;
          if (opcode == OP_ST) begin
            wr_mem = 1'b1;
            if (mem_ready) begin
              upd_pc = 1'b1;
              pc_sel = PC_NPC;
            end
          end
        end
        S_WB: begin
          wr_reg = 1'b1;
          upd_pc = 1'b1;
          pc_sel = PC_NPC;
        end
        S_INTR: begin
          int_ack = 1'b1;
          upd_pc  = 1'b1;
          pc_sel  = PC_VEC;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign in_isr = in_isr_q;
  assign state  = state_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instret_q;

  // Wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      instret_q <= 32'h0;
    else if (retire || halt_enter) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  localparam logic [5:0] OP_ALU  = 6'h00;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_BR   = 6'h04;
  localparam logic [5:0] OP_RETI = 6'h05;
  localparam logic [5:0] OP_NOP  = 6'h10;
  localparam logic [5:0] OP_HALT = 6'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        INT;
  logic        ir_en, upd_pc, rd_mem, wr_mem, wr_reg, int_ack, in_isr, halted;
  logic [1:0]  pc_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .INT(INT),
    .ir_en(ir_en), .upd_pc(upd_pc), .pc_sel(pc_sel), .rd_mem(rd_mem),
    .wr_mem(wr_mem), .wr_reg(wr_reg), .int_ack(int_ack), .in_isr(in_isr),
    .halted(halted), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, upd;
    logic [1:0] sel;
    logic       rd, wr, wreg, ack, isr, hlt;
  } ctl_t;

  ctl_t        exp_q[$];
  logic [31:0] ret_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ctl_t        e, a;
      logic [31:0] er;
      string       nm;
      e  = exp_q.pop_front();
      er = ret_q.pop_front();
      nm = name_q.pop_front();
      a  = '{state, ir_en, upd_pc, pc_sel, rd_mem, wr_mem, wr_reg, int_ack,
             in_isr, halted};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s ctl: got st=%0d ir=%b upd=%b sel=%b rd=%b wr=%b wreg=%b ack=%b isr=%b hlt=%b, want st=%0d ir=%b upd=%b sel=%b rd=%b wr=%b wreg=%b ack=%b isr=%b hlt=%b",
                 nm, a.st, a.ir, a.upd, a.sel, a.rd, a.wr, a.wreg, a.ack, a.isr, a.hlt,
                 e.st, e.ir, e.upd, e.sel, e.rd, e.wr, e.wreg, e.ack, e.isr, e.hlt);
      end
      n_checks++;
      if (instret !== er) begin
        n_fail++;
        $display("FAIL %s instret: got %0d want %0d", nm, instret, er);
      end
    end
  end

  // Drive one cycle of inputs and queue the hand-computed response.
  // ret is the retire count with the counter built; 0 otherwise.
  task automatic cyc(input string nm, input logic r, input logic [5:0] op,
                     input logic mr, input logic it, input logic [2:0] st,
                     input logic ir, input logic upd, input logic [1:0] sel,
                     input logic rd, input logic wr, input logic wreg,
                     input logic ack, input logic isr, input logic hlt,
                     input int ret);
    rst       = r;
    opcode    = op;
    mem_ready = mr;
    INT       = it;
    exp_q.push_back('{st, ir, upd, sel, rd, wr, wreg, ack, isr, hlt});
`ifdef SEQ_PERF_CNT_EN
    ret_q.push_back(32'(ret));
`else
    ret_q.push_back(32'h0);
`endif
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; opcode = OP_ALU; mem_ready = 1'b1; INT = 1'b0;
    @(posedge clk); #1;
    //      name      rst op       mr it  st ir up sel   rd wr wg ak is hl ret
    cyc("reset",      0, OP_ALU,  1, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    // ALU: 0,1,2,4
    cyc("alu_f",      1, OP_ALU,  1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("alu_d",      1, OP_ALU,  1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("alu_e",      1, OP_ALU,  1, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("alu_wb",     1, OP_ALU,  1, 0,  4, 0, 1, 2'd0, 0, 0, 1, 0, 0, 0, 0);
    // LD with three wait cycles
    cyc("ld_f",       1, OP_LD,   0, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    cyc("ld_d",       1, OP_LD,   0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    cyc("ld_e",       1, OP_LD,   0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 1);
    cyc("ld_m0",      1, OP_LD,   0, 0,  3, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1);
    cyc("ld_m1",      1, OP_LD,   0, 0,  3, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1);
    cyc("ld_m2",      1, OP_LD,   0, 0,  3, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1);
    cyc("ld_m3",      1, OP_LD,   1, 0,  3, 0, 0, 2'd0, 1, 0, 0, 0, 0, 0, 1);
    cyc("ld_wb",      1, OP_LD,   1, 0,  4, 0, 1, 2'd0, 0, 0, 1, 0, 0, 0, 1);
    // BR
    cyc("br_f",       1, OP_BR,   1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2);
    cyc("br_d",       1, OP_BR,   1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2);
    cyc("br_e",       1, OP_BR,   1, 0,  2, 0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 2);
    // NOP (undefined opcode)
    cyc("nop_f",      1, OP_NOP,  1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 3);
    cyc("nop_d",      1, OP_NOP,  1, 0,  1, 0, 1, 2'd0, 0, 0, 0, 0, 0, 0, 3);
    // ST with INT held: interrupt entry after retire
    cyc("st_f",       1, OP_ST,   0, 1,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 4);
    cyc("st_d",       1, OP_ST,   0, 1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 4);
    cyc("st_e",       1, OP_ST,   0, 1,  2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 4);
    cyc("st_m0",      1, OP_ST,   0, 1,  3, 0, 0, 2'd0, 0, 1, 0, 0, 0, 0, 4);
    cyc("st_m1",      1, OP_ST,   1, 1,  3, 0, 1, 2'd0, 0, 1, 0, 0, 0, 0, 4);
    cyc("intr1",      1, OP_ALU,  1, 1,  5, 0, 1, 2'd2, 0, 0, 0, 1, 0, 0, 5);
    // Inside ISR, INT still high: no nesting
    cyc("isr_alu_f",  1, OP_ALU,  1, 1,  0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0, 5);
    cyc("isr_alu_d",  1, OP_ALU,  1, 1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 5);
    cyc("isr_alu_e",  1, OP_ALU,  1, 1,  2, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 5);
    cyc("isr_alu_wb", 1, OP_ALU,  1, 1,  4, 0, 1, 2'd0, 0, 0, 1, 0, 1, 0, 5);
    // RETI: returns to FETCH despite INT, in_isr clears
    cyc("reti_f",     1, OP_RETI, 1, 1,  0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0, 6);
    cyc("reti_d",     1, OP_RETI, 1, 1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 6);
    cyc("reti_e",     1, OP_RETI, 1, 1,  2, 0, 1, 2'd3, 0, 0, 0, 0, 1, 0, 6);
    // One more instruction, then the pending INT is taken
    cyc("post_f",     1, OP_ALU,  1, 1,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 7);
    cyc("post_d",     1, OP_ALU,  1, 1,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 7);
    cyc("post_e",     1, OP_ALU,  1, 1,  2, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 7);
    cyc("post_wb",    1, OP_ALU,  1, 1,  4, 0, 1, 2'd0, 0, 0, 1, 0, 0, 0, 7);
    cyc("intr2",      1, OP_RETI, 1, 0,  5, 0, 1, 2'd2, 0, 0, 0, 1, 0, 0, 8);
    cyc("reti2_f",    1, OP_RETI, 1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0, 8);
    cyc("reti2_d",    1, OP_RETI, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 8);
    cyc("reti2_e",    1, OP_RETI, 1, 0,  2, 0, 1, 2'd3, 0, 0, 0, 0, 1, 0, 8);
    // HALT, then wake on INT
    cyc("halt_f",     1, OP_HALT, 1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 9);
    cyc("halt_d",     1, OP_HALT, 1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 9);
    cyc("halt0",      1, OP_HALT, 1, 0,  6, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 10);
    cyc("halt1",      1, OP_HALT, 1, 0,  6, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 10);
    cyc("halt_wake",  1, OP_HALT, 1, 1,  6, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1, 10);
    cyc("intr3",      1, OP_ST,   0, 0,  5, 0, 1, 2'd2, 0, 0, 0, 1, 0, 0, 10);
    // ST stalled in MEM, then reset asserted mid-cycle
    cyc("st2_f",      1, OP_ST,   0, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 1, 0, 10);
    cyc("st2_d",      1, OP_ST,   0, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 10);
    cyc("st2_e",      1, OP_ST,   0, 0,  2, 0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 10);
    cyc("st2_m",      1, OP_ST,   0, 0,  3, 0, 0, 2'd0, 0, 1, 0, 0, 1, 0, 10);
    cyc("rst_async",  0, OP_ST,   0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rst_hold",   0, OP_ST,   0, 0,  0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rel_f",      1, OP_ALU,  1, 0,  0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    cyc("rel_d",      1, OP_ALU,  1, 0,  1, 0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
